// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (8N1 by default)
//
// Purpose
//   Receives asynchronous serial frames: one start bit, DATA_BITS data bits
//   LSB-first, and one stop bit. The line is oversampled on rx_tick (OS_RATE
//   ticks per bit period). The start bit is confirmed at its middle, and each
//   later bit is sampled one full bit period after the previous sample.
//
// Parameters
//   DATA_BITS  data bits per frame, 1..8
//   OS_RATE    rx_tick pulses per bit period. Only 16 is supported because
//              os_cnt is a 4-bit counter.
//
// Ports
//   clk          in   system clock. All logic runs on the rising edge.
//   rst_n        in   asynchronous active-low reset
//   rx_tick      in   one-clk oversample enable, OS_RATE pulses per bit
//   rx           in   asynchronous serial line, idle high
//   data         out  last correctly framed character, registered
//   data_valid   out  one-clk pulse in the cycle that data is updated
//   frame_error  out  one-clk pulse when the stop bit is sampled low
//   busy         out  high whenever the receiver is not in IDLE
//
// Notes
//   - The FSM, both counters and the shift register advance only on clk
//     edges where rx_tick=1. Holding rx_tick low freezes reception.
//   - data_valid and frame_error are cleared on every clk edge. They are set
//     on the sampling tick edge, so each pulse lasts exactly one clk cycle.
//   - There is no handshake. Each data_valid overwrites data, so a consumer
//     must capture data on the pulse.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  // -------------------------------------------------------------------------
  // Local constants
  // -------------------------------------------------------------------------
  // bit_cnt counts 0..DATA_BITS, so it needs room for the value DATA_BITS.
  localparam int BCW = $clog2(DATA_BITS + 1);

  // START confirms the start bit at mid-bit, which is OS_RATE/2 ticks after
  // the detecting tick. DATA and STOP sample every OS_RATE ticks after that.
  localparam logic [3:0]     OS_MID   = 4'(OS_RATE / 2 - 1);
  localparam logic [3:0]     OS_LAST  = 4'(OS_RATE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic                 rx_meta_q;     // first synchronizer flop
  logic                 rx_s_q;        // synchronized serial line
  state_e               state_q;
  logic [3:0]           os_cnt_q;      // oversample counter, modulo 16
  logic [BCW-1:0]       bit_cnt_q;     // data bits sampled so far
  logic [DATA_BITS-1:0] shift_q;       // character being assembled
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 data_valid_q;
  logic                 frame_error_q;
  logic                 busy_q;

  // -------------------------------------------------------------------------
  // Input synchronizer
  // -------------------------------------------------------------------------
  // Both flops run freely on clk and ignore rx_tick, so rx_s is settled
  // whenever a tick samples it. Both flops reset to the idle-high line level,
  // so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge value of its source. Here that keeps the two
      // synchronizer stages distinct.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Shift-register next value
  // -------------------------------------------------------------------------
  // Bits arrive LSB-first. Each sample shifts right and enters at the MSB,
  // so after DATA_BITS samples the first bit received sits in bit 0. Writing
  // it as a shift plus one bit write also covers DATA_BITS == 1.
  always_comb begin
    // NOTE: assign a full default before any partial or conditional write in
    // combinational logic. That way no path leaves the output unassigned,
    // which would infer a latch.
    shift_d                = shift_q >> 1;
    shift_d[DATA_BITS-1]   = rx_s_q;
  end

  // -------------------------------------------------------------------------
  // Receive FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      os_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // Pulses are cleared on every clk edge, not only on tick edges. The
      // case statement below sets them for the single cycle after a
      // sampling tick.
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;

      if (rx_tick) begin
        unique case (state_q)
          S_IDLE: begin
            if (!rx_s_q) begin
              state_q  <= S_START;
              os_cnt_q <= '0;
              busy_q   <= 1'b1;
            end
          end

          S_START: begin
            if (os_cnt_q == OS_MID) begin
              os_cnt_q <= '0;
              if (!rx_s_q) begin
                // Line is still low at mid-bit: a real start bit.
                state_q   <= S_DATA;
                bit_cnt_q <= '0;
              end else begin
                // The line went high again before mid-bit. Treat it as a
                // glitch and drop it silently.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end

          S_DATA: begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q  <= '0;
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + BCW'(1);
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= S_STOP;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end

          S_STOP: begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q <= '0;
              if (rx_s_q) begin
                // Stop bit is good: publish the character.
                data_q       <= shift_q;
                data_valid_q <= 1'b1;
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
              end else begin
                // Stop bit is low: framing error or break. Keep the last
                // good data. WAIT_IDLE then swallows the rest of a held
                // break, so a break gives only one error pulse.
                frame_error_q <= 1'b1;
                state_q       <= S_WAIT_IDLE;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end

          S_WAIT_IDLE: begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q  <= S_IDLE;
            os_cnt_q <= '0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- scoreboard testbench for uart_rx
//
// The stimulus thread drives serial frames and pushes the response each
// frame should produce (a data_valid carrying a byte, or a frame_error with
// data unchanged) into a queue. A separate monitor pops the queue whenever
// the DUT pulses data_valid or frame_error.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DATA_BITS = 8;
  localparam int TICK_DIV  = 4;   // clk cycles per rx_tick

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .OS_RATE   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_tick     (rx_tick),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   tick_cnt     = 0;
  int   pulse_tick   = 0;
  int   busy_clks    = 0;
  bit   tick_en      = 1'b1;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // -------------------------------------------------------------------------
  // Tick generator, tick counter, busy-cycle counter
  // -------------------------------------------------------------------------
  initial begin
    int div_cnt = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        if (div_cnt == TICK_DIV - 1) begin
          div_cnt = 0;
          rx_tick = 1'b1;
        end else begin
          div_cnt++;
          rx_tick = 1'b0;
        end
      end else begin
        rx_tick = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (rx_tick) tick_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) busy_clks++;
  end

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  initial forever begin
    @(negedge clk);
    if (data_valid || frame_error) begin
      pulse_tick = tick_cnt;
      check("pulse_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, data_valid, frame_error}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_is_error", {31'd0, frame_error}, {31'd0, e.is_err});
        check("pulse_data", {24'd0, data}, {24'd0, e.data});
        // busy falls with data_valid but stays high through a frame error.
        check("busy_at_pulse", {31'd0, busy}, {31'd0, e.is_err});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (rx_tick !== 1'b1);
    end
  endtask

  // Drive one bit for 16 ticks. With freeze set, stop rx_tick halfway
  // through the bit for 10000 clks and toggle rx while ticks are stopped.
  task automatic send_bit(input logic v, input bit freeze = 1'b0);
    @(negedge clk);
    rx = v;
    if (freeze) begin
      wait_ticks(8);
      tick_en = 1'b0;
      repeat (5000) @(negedge clk);
      rx = ~v;
      repeat (2500) @(negedge clk);
      rx = v;
      repeat (2500) @(negedge clk);
      check("busy_while_frozen", {31'd0, busy}, 32'd1);
      tick_en = 1'b1;
      wait_ticks(8);
    end else begin
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int freeze_bit = -1);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(b[i], (i == freeze_bit));
    send_bit(1'b1);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    sb.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] last_good);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    sb.push_back(e);
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int start_tick;
    logic [7:0] b3c;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_data", {24'd0, data}, 32'h0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);

    // 0xA5 with a good stop bit. Also measures the start-to-stop latency.
    expect_byte(8'hA5);
    @(negedge clk);
    start_tick = tick_cnt;
    rx = 1'b0;
    wait_ticks(16);
    #1;
    check("a5_busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < DATA_BITS; i++) send_bit(((8'hA5 >> i) & 8'h1) != 0);
    send_bit(1'b1);
    wait_ticks(10);
    // Pulse is seen after the 153rd tick from the line fall, i.e. 152 ticks
    // after the start-detecting tick.
    check("a5_latency_ticks", pulse_tick - start_tick, 32'd153);

    // Glitch: 4 ticks low, then high. busy should be high for 8 ticks.
    @(negedge clk);
    busy_clks = 0;
    rx = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_busy_clks", busy_clks, 8 * TICK_DIV);
    check("glitch_data_kept", {24'd0, data}, 32'hA5);

    // 0x3C whose stop bit is held low for 30 ticks (break).
    expect_ferr(8'hA5);
    b3c = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(b3c[i]);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(30);
    #1;
    check("break_busy_held", {31'd0, busy}, 32'd1);
    check("break_data_kept", {24'd0, data}, 32'hA5);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(2);
    #1;
    check("break_busy_released", {31'd0, busy}, 32'd0);
    wait_ticks(16);

    // Back-to-back frames with no idle bits between them.
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00);
    send_frame(8'hFF);
    wait_ticks(10);

    // Reset in the middle of 0x81 (after 3 data bits), then 0x55.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("midreset_data", {24'd0, data}, 32'h0);
    check("midreset_data_valid", {31'd0, data_valid}, 32'd0);
    check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);
    expect_byte(8'h55);
    send_frame(8'h55);
    wait_ticks(10);

    // 0x96 with rx_tick stopped for 10000 clks in the middle of data bit 3.
    expect_byte(8'h96);
    send_frame(8'h96, 3);
    wait_ticks(10);
    #1;
    check("freeze_busy_after", {31'd0, busy}, 32'd0);

    wait_ticks(20);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
